wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single 32-bit writeback port between 8 requesters
//  (ALU, LSU, CSR, MUL/DIV, etc.). Picks one requester, steers its data through an
//  8:1 select to the port, and holds the grant over bursts with a valid/ready handshake.
//  Forced rotation after MAX_BURST beats bounds starvation.
// PARAMETERS
//  DATA_W     32  width of each requester data word and of out_data
//  MAX_BURST  4   max beats accepted per grant before forced release (>=1)
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  req_i      in   8      per-requester request; held high until its last beat is acked
//  last_i     in   8      per-requester "current beat is final of burst"
//  data_i     in   8*32   flattened requester data, slice i = data_i[i*32 +: 32]
//  out_ready  in   1      writeback port accepts current beat
//  out_valid  out  1      beat present on out_data
//  out_data   out  32     granted requester's data; 0 when out_valid=0
//  sel_o      out  3      index of granted requester (drives the 8:1 select)
//  gnt_o      out  8      one-hot grant, 0 in IDLE
//  ack_o      out  8      one-hot beat-accepted pulse = gnt_o & {8{out_valid & out_ready}}
//  err_o      out  1      sticky protocol-violation flag, cleared only by reset
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, gnt_o=0, sel_o=0, ptr=0, beat_cnt=0,
//   out_valid=0, out_data=0, ack_o=0, err_o=0.
//  States: IDLE, BUSY.
//  IDLE: if |req_i, pick first set bit scanning circularly from ptr; register gnt_o/sel_o,
//   beat_cnt=0 -> BUSY. Latency: req at edge N -> out_valid=1 after edge N+1.
//  BUSY: out_valid=1; out_data=data_i slice sel_o (combinational, live data).
//   out_ready=0: hold everything, no ack, beat_cnt unchanged (indefinite backpressure legal).
//   Beat accepted (out_ready=1): ack_o[sel_o]=1 same cycle; beat_cnt++.
//   Release when accepted beat has last_i[sel_o]=1 OR beat_cnt==MAX_BURST-1.
//   On release: ptr<=(sel_o+1) mod 8 (7 wraps to 0); re-arbitrate same edge from new ptr
//   over current req_i with req_i[sel_o] masked unless it also requests a new burst
//   (releasing requester is lowest priority). Pending req -> stay BUSY with new grant,
//   no bubble; none -> IDLE.
//  Forced release (MAX_BURST hit, last_i=0): requester keeps req_i high; it re-competes
//   and resumes its burst on a later grant; beat_cnt restarts at 0.
//  Violation: req_i[sel_o] falls in BUSY before its last beat is acked -> err_o<=1,
//   gnt_o<=0, out_valid<=0, ptr<=(sel_o+1) mod 8, state IDLE. err_o stays 1.
//  Requests/last_i of non-granted requesters are ignored while BUSY.
//  beat_cnt width = $clog2(MAX_BURST+1); never exceeds MAX_BURST-1.
//  Grant changes only on a clock edge; sel_o, gnt_o always mutually consistent.
// STRUCTURE
//  Shared package cpu32b_arb_pkg: NUM_REQ=8, SEL_W=3, arb_state_t {IDLE,BUSY}.
//  Sub-module rr_pick8: combinational (req[7:0], ptr[2:0]) -> (found, idx[2:0]),
//   circular first-set search. Data steering reuses existing Mux_8to1, sel=sel_o,
//   output gated by out_valid. FSM, ptr, beat_cnt, err_o in this module.
// TESTING
//  1 req_i=8'h04, last_i=8'hFF, out_ready=1 -> next cycle gnt_o=8'h04, sel_o=2,
//    out_data=data2, ack_o=8'h04 one cycle, then IDLE, ptr=3.
//  2 req_i=8'hFF held, all single-beat, ready=1 -> sel_o 0,1,..,7,0 on consecutive
//    cycles, out_valid never drops.
//  3 MAX_BURST=4, req_i[5] burst last_i=0, req_i[1] also pending -> 4 acks to 5, then
//    grant 1 (ptr wraps 6->7->0->1), then 5 again.
//  4 Grant held, out_ready=0 for 10 cycles -> out_valid=1, sel_o/out_data stable,
//    ack_o=0, beat_cnt unchanged; ready=1 -> single ack.
//  5 BUSY on requester 3, drop req_i[3] before last ack -> err_o=1, gnt_o=0,
//    out_valid=0 next edge; err_o stays 1 through later grants.
//  6 Assert rst_n=0 mid-burst between edges -> all outputs 0 immediately; after release
//    with req_i=8'h81 first grant is requester 0.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the writeback-port arbiter.
package cpu32b_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Index following s, wrapping 7 -> 0.
    function automatic logic [SEL_W-1:0] ptr_after(input logic [SEL_W-1:0] s);
        return s + SEL_W'(1);
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Requester-side bus of the writeback arbiter: requests, burst data and the
// single shared writeback port.
interface wb_port_arbiter_if #(parameter int DATA_W = 32) ();
    import cpu32b_arb_pkg::*;

    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ-1:0]        last_i;
    logic [NUM_REQ*DATA_W-1:0] data_i;
    logic                      out_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [SEL_W-1:0]          sel_o;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [NUM_REQ-1:0]        ack_o;
    logic                      err_o;

    modport master (
        output req_i, last_i, data_i, out_ready,
        input  out_valid, out_data, sel_o, gnt_o, ack_o, err_o
    );

    modport slave (
        input  req_i, last_i, data_i, out_ready,
        output out_valid, out_data, sel_o, gnt_o, ack_o, err_o
    );

endinterface

// File: rtl/Mux_8to1.sv
// Plain 8:1 word select.
module Mux_8to1 #(
    parameter int W = 32
) (
    input  logic [8*W-1:0] d,
    input  logic [2:0]     sel,
    output logic [W-1:0]   y
);

    // Pick word sel out of the flattened input.
    always_comb begin
        y = d[32'(sel)*W +: W];
    end

endmodule

// File: rtl/wb_port_arbiter_rr_pick8.sv
// Circular first-set search: first requester at or after ptr, wrapping.
module rr_pick8
    import cpu32b_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    // Walk ptr, ptr+1, ... (mod 8) and stop at the first asserted request.
    always_comb begin
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr + SEL_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the shared writeback port.
//
//   state | meaning
//   IDLE  | no grant; arbitrate from ptr over req_i
//   BUSY  | one requester granted; beats move on out_valid & out_ready
//
// A grant is released on its last beat or after MAX_BURST beats; the next
// owner is chosen on the same edge so back-to-back grants have no bubble.
module wb_port_arbiter
    import cpu32b_arb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_port_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    logic               own_req;
    logic               own_last;
    logic               beat_ok;
    logic [NUM_REQ-1:0] pick_req;
    logic [SEL_W-1:0]   pick_ptr;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic [DATA_W-1:0]  mux_y;

    assign own_req  = bus.req_i[sel_q];
    assign own_last = bus.last_i[sel_q];
    assign beat_ok  = valid_q & bus.out_ready;

    // Arbitration inputs: from ptr when idle; on release from the slot after
    // the owner, with the owner dropped if its burst just finished.
    always_comb begin
        pick_req = bus.req_i;
        pick_ptr = ptr_q;
        if (state_q == BUSY) begin
            pick_ptr = ptr_after(sel_q);
            if (own_last) begin
                pick_req[sel_q] = 1'b0;
            end
        end
    end

    rr_pick8 u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state logic for grant, pointer, beat count and error flag.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                end
            end
            BUSY: begin
                if (!own_req) begin
                    // Owner abandoned its burst: flag it and drop the grant.
                    err_d   = 1'b1;
                    state_d = IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = ptr_after(sel_q);
                    cnt_d   = '0;
                end else if (beat_ok) begin
                    if (own_last || (cnt_q == CNT_LAST)) begin
                        ptr_d = ptr_after(sel_q);
                        cnt_d = '0;
                        if (pick_found) begin
                            gnt_d = NUM_REQ'(1) << pick_idx;
                            sel_d = pick_idx;
                        end else begin
                            state_d = IDLE;
                            gnt_d   = '0;
                            valid_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    Mux_8to1 #(.W(DATA_W)) u_mux (
        .d   (bus.data_i),
        .sel (sel_q),
        .y   (mux_y)
    );

    assign bus.out_valid = valid_q;
    assign bus.out_data  = valid_q ? mux_y : '0;
    assign bus.sel_o     = sel_q;
    assign bus.gnt_o     = gnt_q;
    assign bus.ack_o     = gnt_q & {NUM_REQ{beat_ok}};
    assign bus.err_o     = err_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: randomized bursts scored against a queue-based
// reference, followed by directed corner cases.
module tb_wb_port_arbiter;
    import cpu32b_arb_pkg::*;

    localparam int DW = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DATA_W(DW)) bus ();

    wb_port_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [34:0] exp_q[$];
    bit sb_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_i = '0;
        bus.last_i = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_dir_data();
        for (int i = 0; i < 8; i++) bus.data_i[i*32 +: 32] = 32'hD000_0000 | 32'(i);
    endtask

    // Scoreboard monitor: every accepted beat must match the oldest prediction.
    initial begin
        logic [34:0] e;
        logic [7:0] oh;
        forever begin
            @(negedge clk);
            #2;
            if (sb_en && rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected_beat: got beat from %0d expected none", bus.sel_o);
                end else begin
                    e = exp_q.pop_front();
                    oh = 8'b1 << e[34:32];
                    chk("sb_sel", 64'(bus.sel_o), 64'(e[34:32]));
                    chk("sb_data", 64'(bus.out_data), 64'(e[31:0]));
                    chk("sb_ack", 64'(bus.ack_o), 64'(oh));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int rem[8];
        logic [31:0] cur[8];
        int owner, ptr, beats;
        bit stop_new, done, was_last;
        logic [7:0] rq, cand;
        int exp_sel[6];

        bus.req_i = '0;
        bus.last_i = '0;
        bus.data_i = '0;
        bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_gnt", 64'(bus.gnt_o), 0);
        chk("reset_sel", 64'(bus.sel_o), 0);
        chk("reset_valid", 64'(bus.out_valid), 0);
        chk("reset_data", 64'(bus.out_data), 0);
        chk("reset_ack", 64'(bus.ack_o), 0);
        chk("reset_err", 64'(bus.err_o), 0);

        // ---------------- randomized phase ----------------
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rem[i] = 0;
            cur[i] = $urandom;
        end
        owner = -1;
        ptr = 0;
        beats = 0;
        stop_new = 1'b0;
        done = 1'b0;
        sb_en = 1'b1;
        for (int cyc = 0; cyc < 2800 && !done; cyc++) begin
            if (cyc == 2500) stop_new = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if (rem[i] == 0 && !stop_new && $urandom_range(0, 3) == 0)
                    rem[i] = $urandom_range(1, 7);
            end
            for (int i = 0; i < 8; i++) begin
                rq[i] = (rem[i] != 0);
                bus.last_i[i] = (rem[i] == 1);
                bus.data_i[i*32 +: 32] = cur[i];
            end
            bus.req_i = rq;
            bus.out_ready = stop_new ? 1'b1 : ($urandom_range(0, 3) != 0);
            // Reference: one owner at a time, rotate on finished or capped burst.
            if (owner < 0) begin
                owner = pick(rq, ptr);
                beats = 0;
            end else if (bus.out_ready) begin
                exp_q.push_back({3'(owner), cur[owner]});
                beats++;
                was_last = (rem[owner] == 1);
                rem[owner]--;
                cur[owner] = $urandom;
                if (was_last || beats == MB) begin
                    ptr = (owner + 1) % 8;
                    cand = rq;
                    if (was_last) cand[owner] = 1'b0;
                    owner = pick(cand, ptr);
                    beats = 0;
                end
            end
            if (stop_new && owner < 0) begin
                done = 1'b1;
                for (int i = 0; i < 8; i++) if (rem[i] != 0) done = 1'b0;
            end
        end
        @(negedge clk);
        bus.req_i = '0;
        #3;
        chk("sb_drained", 64'(done), 1);
        chk("sb_queue_empty", 64'(exp_q.size()), 0);
        chk("rand_err_clear", 64'(bus.err_o), 0);
        chk("rand_idle_valid", 64'(bus.out_valid), 0);
        sb_en = 1'b0;

        // ---------------- directed: single beat, ptr advance ----------------
        do_reset();
        set_dir_data();
        bus.req_i = 8'h04; bus.last_i = 8'hFF; bus.out_ready = 1'b1;
        step(); #1;
        chk("t1_gnt", 64'(bus.gnt_o), 64'h04);
        chk("t1_sel", 64'(bus.sel_o), 2);
        chk("t1_valid", 64'(bus.out_valid), 1);
        chk("t1_data", 64'(bus.out_data), 64'hD000_0002);
        chk("t1_ack", 64'(bus.ack_o), 64'h04);
        step();
        bus.req_i = 8'h00;
        #1;
        chk("t1_idle_gnt", 64'(bus.gnt_o), 0);
        chk("t1_idle_valid", 64'(bus.out_valid), 0);
        chk("t1_idle_data", 64'(bus.out_data), 0);
        chk("t1_idle_ack", 64'(bus.ack_o), 0);
        bus.req_i = 8'h09;
        step(); #1;
        chk("t1_ptr3_sel", 64'(bus.sel_o), 3);

        // ---------------- directed: full rotation ----------------
        do_reset();
        bus.req_i = 8'hFF; bus.last_i = 8'hFF; bus.out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step(); #1;
            chk("t2_sel", 64'(bus.sel_o), 64'(k % 8));
            chk("t2_valid", 64'(bus.out_valid), 1);
        end

        // ---------------- directed: forced rotation ----------------
        do_reset();
        exp_sel = '{5, 5, 5, 5, 1, 5};
        bus.req_i = 8'h20; bus.last_i = 8'h02; bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (k == 1) bus.req_i = 8'h22;
            if (k == 5) bus.req_i = 8'h20;
            #1;
            chk("t3_sel", 64'(bus.sel_o), 64'(exp_sel[k]));
            chk("t3_ack", 64'(bus.ack_o), 64'(8'b1 << exp_sel[k]));
        end

        // ---------------- directed: backpressure ----------------
        do_reset();
        bus.req_i = 8'h08; bus.last_i = 8'h00; bus.out_ready = 1'b0;
        step();
        bus.req_i = 8'h18;
        #1;
        chk("t4_sel", 64'(bus.sel_o), 3);
        for (int k = 0; k < 10; k++) begin
            step(); #1;
            chk("t4_hold_valid", 64'(bus.out_valid), 1);
            chk("t4_hold_sel", 64'(bus.sel_o), 3);
            chk("t4_hold_data", 64'(bus.out_data), 64'hD000_0003);
            chk("t4_hold_ack", 64'(bus.ack_o), 0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("t4_ack", 64'(bus.ack_o), 64'h08);
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            chk("t4_burst_sel", 64'(bus.sel_o), 3);
        end
        step(); #1;
        chk("t4_rotate_sel", 64'(bus.sel_o), 4);

        // ---------------- directed: protocol violation ----------------
        do_reset();
        bus.req_i = 8'h08; bus.last_i = 8'h00; bus.out_ready = 1'b0;
        step(); #1;
        chk("t5_sel", 64'(bus.sel_o), 3);
        bus.req_i = 8'h00;
        step(); #1;
        chk("t5_err", 64'(bus.err_o), 1);
        chk("t5_gnt", 64'(bus.gnt_o), 0);
        chk("t5_valid", 64'(bus.out_valid), 0);
        bus.req_i = 8'h01; bus.last_i = 8'h01; bus.out_ready = 1'b1;
        step(); #1;
        chk("t5_regrant_sel", 64'(bus.sel_o), 0);
        chk("t5_regrant_err", 64'(bus.err_o), 1);
        step();
        bus.req_i = 8'h00;
        #1;
        chk("t5_err_sticky", 64'(bus.err_o), 1);

        // ---------------- directed: async reset mid-burst ----------------
        do_reset();
        bus.req_i = 8'h04; bus.last_i = 8'h00; bus.out_ready = 1'b1;
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_gnt", 64'(bus.gnt_o), 0);
        chk("t6_sel", 64'(bus.sel_o), 0);
        chk("t6_valid", 64'(bus.out_valid), 0);
        chk("t6_data", 64'(bus.out_data), 0);
        chk("t6_ack", 64'(bus.ack_o), 0);
        rst_n = 1'b1;
        bus.req_i = 8'h81; bus.last_i = 8'hFF;
        step(); #1;
        chk("t6_first_sel", 64'(bus.sel_o), 0);
        chk("t6_first_gnt", 64'(bus.gnt_o), 64'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
